// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving the {w,x,y,z} select code of decoder_4to16, free-running or per step.
// Define DECODER_SCAN_WRAP_EN to wrap to code 0 on completion instead of stopping in DONE.
module decoder_scan_sequencer #(
  parameter int unsigned DWELL     = 4,
  parameter int unsigned LAST_CODE = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       step_mode,
  input  logic       step,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       active,
  output logic       code_adv,
  output logic       done,
  output logic [3:0] pass_cnt
);

  localparam logic [7:0] DwellLast = 8'(DWELL - 1);
  localparam logic [3:0] LastCode  = 4'(LAST_CODE);

  typedef enum logic [1:0] {StIdle, StRun, StStep, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] code_q, code_d;
  logic [7:0] dwell_q, dwell_d;
  logic [3:0] pass_q, pass_d;
  logic       active_q, active_d;
  logic       code_adv_q, code_adv_d;
  logic       done_q, done_d;
  logic       complete;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    dwell_d    = dwell_q;
    pass_d     = pass_q;
    code_adv_d = 1'b0;
    done_d     = 1'b0;
    complete   = 1'b0;

    if (abort) begin
      state_d = StIdle;
      code_d  = '0;
      dwell_d = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d    = step_mode ? StStep : StRun;
            code_d     = '0;
            dwell_d    = '0;
            code_adv_d = 1'b1;
          end
        end
        StRun: begin
          if (dwell_q == DwellLast) begin
            dwell_d = '0;
            if (code_q != LastCode) begin
              code_d     = code_q + 4'd1;
              code_adv_d = 1'b1;
            end else begin
              complete = 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
        StStep: begin
          if (step) begin
            if (code_q != LastCode) begin
              code_d     = code_q + 4'd1;
              code_adv_d = 1'b1;
            end else begin
              complete = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (complete) begin
      done_d = 1'b1;
      pass_d = (pass_q == 4'hf) ? pass_q : pass_q + 4'd1;
`ifdef DECODER_SCAN_WRAP_EN
      code_d     = '0;
      code_adv_d = 1'b1;
`else
      state_d = StDone;
`endif
    end

    // Registered from the next state so active lines up with the code it qualifies.
    active_d = (state_d == StRun) || (state_d == StStep);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      code_q     <= '0;
      dwell_q    <= '0;
      pass_q     <= '0;
      active_q   <= 1'b0;
      code_adv_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      dwell_q    <= dwell_d;
      pass_q     <= pass_d;
      active_q   <= active_d;
      code_adv_q <= code_adv_d;
      done_q     <= done_d;
    end
  end

  assign {w, x, y, z} = code_q;
  assign active       = active_q;
  assign code_adv     = code_adv_q;
  assign done         = done_q;
  assign pass_cnt     = pass_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench for decoder_scan_sequencer: expected code_adv/done events are queued with
// their cycle stamps and popped by per-instance monitors. Honours DECODER_SCAN_WRAP_EN.
module tb_decoder_scan_sequencer;

`ifdef DECODER_SCAN_WRAP_EN
  localparam int unsigned DwellA = 2;
`else
  localparam int unsigned DwellA = 4;
`endif
  localparam int unsigned LastA = 15;
  localparam int unsigned ScanA = (LastA + 1) * DwellA;

  typedef struct {
    int unsigned cyc;
    bit          adv;
    bit          dn;
    logic [3:0]  code;
    logic [3:0]  pass;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, start_a, start_b, abort, step_mode, step;
  logic       wa, xa, ya, za, active_a, adv_a, done_a;
  logic       wb, xb, yb, zb, active_b, adv_b, done_b;
  logic [3:0] pass_a, pass_b;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         qa[$];
  ev_t         qb[$];

  decoder_scan_sequencer #(.DWELL(DwellA), .LAST_CODE(LastA)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .step_mode(step_mode), .step(step),
    .w(wa), .x(xa), .y(ya), .z(za), .active(active_a), .code_adv(adv_a), .done(done_a),
    .pass_cnt(pass_a)
  );

  decoder_scan_sequencer #(.DWELL(1), .LAST_CODE(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .step_mode(step_mode), .step(step),
    .w(wb), .x(xb), .y(yb), .z(zb), .active(active_b), .code_adv(adv_b), .done(done_b),
    .pass_cnt(pass_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack(input int unsigned c, input bit adv, input bit dn,
                                       input logic [3:0] code, input logic [3:0] pass);
    return {22'd0, c, adv, dn, code, pass};
  endfunction

  task automatic push_a(input int unsigned c, input bit adv, input bit dn, input int code,
                        input int pass);
    ev_t e;
    e.cyc = c; e.adv = adv; e.dn = dn; e.code = 4'(code); e.pass = 4'(pass);
    qa.push_back(e);
  endtask

  task automatic push_b(input int unsigned c, input bit adv, input bit dn, input int pass);
    ev_t e;
    e.cyc = c; e.adv = adv; e.dn = dn; e.code = 4'd0; e.pass = 4'(pass);
    qb.push_back(e);
  endtask

  // Packs {active, code_adv, done, code, pass_cnt} for direct output checks.
  task automatic check_a(input string name, input int code, input bit act, input bit adv,
                         input bit dn, input int pass);
    do_check(name, 64'({active_a, adv_a, done_a, wa, xa, ya, za, pass_a}),
             64'({act, adv, dn, 4'(code), 4'(pass)}));
  endtask

  task automatic check_b(input string name, input bit act, input int pass);
    do_check(name, 64'({active_b, adv_b, done_b, wb, xb, yb, zb, pass_b}),
             64'({act, 1'b0, 1'b0, 4'd0, 4'(pass)}));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (adv_a || done_a) begin
      if (qa.size() == 0) begin
        do_check("a_unexpected_event", pack(cyc, adv_a, done_a, {wa, xa, ya, za}, pass_a),
                 64'(0));
      end else begin
        e = qa.pop_front();
        do_check("a_event", pack(cyc, adv_a, done_a, {wa, xa, ya, za}, pass_a),
                 pack(e.cyc, e.adv, e.dn, e.code, e.pass));
      end
    end else if (qa.size() != 0 && qa[0].cyc <= cyc) begin
      e = qa.pop_front();
      do_check("a_missed_event", pack(cyc, adv_a, done_a, {wa, xa, ya, za}, pass_a),
               pack(e.cyc, e.adv, e.dn, e.code, e.pass));
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (adv_b || done_b) begin
      if (qb.size() == 0) begin
        do_check("b_unexpected_event", pack(cyc, adv_b, done_b, {wb, xb, yb, zb}, pass_b),
                 64'(0));
      end else begin
        e = qb.pop_front();
        do_check("b_event", pack(cyc, adv_b, done_b, {wb, xb, yb, zb}, pass_b),
                 pack(e.cyc, e.adv, e.dn, e.code, e.pass));
      end
    end else if (qb.size() != 0 && qb[0].cyc <= cyc) begin
      e = qb.pop_front();
      do_check("b_missed_event", pack(cyc, adv_b, done_b, {wb, xb, yb, zb}, pass_b),
               pack(e.cyc, e.adv, e.dn, e.code, e.pass));
    end
  end

  initial begin
    int unsigned e0;
    int          n_act;
    int          pb;
    int          gap;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; step_mode = 1'b0; step = 1'b0;
    tick(3);
    rst = 1'b0;
    check_a("reset_a", 0, 1'b0, 1'b0, 1'b0, 0);
    check_b("reset_b", 1'b0, 0);

`ifdef DECODER_SCAN_WRAP_EN
    // Three full wrapping passes, then abort.
    e0 = cyc; start_a = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k <= int'(LastA); k++)
        push_a(e0 + 1 + p * ScanA + k * DwellA, 1'b1, (p > 0) && (k == 0), k, p);
    push_a(e0 + 1 + 3 * ScanA, 1'b1, 1'b1, 0, 3);
    tick(1); start_a = 1'b0;
    n_act = 0;
    for (int i = 0; i < int'(3 * ScanA); i++) begin
      if (active_a) n_act++;
      tick(1);
    end
    do_check("wrap_active_cycles", 64'(n_act), 64'(3 * ScanA));
    check_a("wrap_third_pass", 0, 1'b1, 1'b1, 1'b1, 3);
    abort = 1'b1; tick(1); abort = 1'b0;
    check_a("wrap_abort", 0, 1'b0, 1'b0, 1'b0, 3);
    tick(6);
`else
    // Full free-running scan with a stray start mid-scan.
    e0 = cyc; start_a = 1'b1; step_mode = 1'b0;
    for (int k = 0; k <= int'(LastA); k++) push_a(e0 + 1 + k * DwellA, 1'b1, 1'b0, k, 0);
    push_a(e0 + 1 + ScanA, 1'b0, 1'b1, int'(LastA), 1);
    tick(1); start_a = 1'b0;
    n_act = 0;
    for (int i = 0; i < int'(ScanA) + 6; i++) begin
      if (active_a) n_act++;
      if (i == 9) start_a = 1'b1;
      if (i == 10) start_a = 1'b0;
      tick(1);
    end
    do_check("run_active_cycles", 64'(n_act), 64'(ScanA));
    check_a("run_done_hold", int'(LastA), 1'b0, 1'b0, 1'b0, 1);

    // Step mode with random gaps, then extra steps in DONE.
    e0 = cyc; start_a = 1'b1; step_mode = 1'b1;
    push_a(e0 + 1, 1'b1, 1'b0, 0, 1);
    tick(1); start_a = 1'b0; step_mode = 1'b0;
    for (int s = 1; s <= int'(LastA) + 1; s++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) tick(gap);
      if (s <= int'(LastA)) push_a(cyc + 1, 1'b1, 1'b0, s, 1);
      else push_a(cyc + 1, 1'b0, 1'b1, int'(LastA), 2);
      step = 1'b1; tick(1); step = 1'b0;
    end
    step = 1'b1; tick(2); step = 1'b0; tick(2);
    check_a("step_done_hold", int'(LastA), 1'b0, 1'b0, 1'b0, 2);

    // Abort together with start while code 7 is showing.
    e0 = cyc; start_a = 1'b1;
    for (int k = 0; k <= 7; k++) push_a(e0 + 1 + k * DwellA, 1'b1, 1'b0, k, 2);
    tick(1); start_a = 1'b0;
    tick(7 * DwellA + 1);
    abort = 1'b1; start_a = 1'b1;
    tick(1); abort = 1'b0; start_a = 1'b0;
    check_a("abort_idle", 0, 1'b0, 1'b0, 1'b0, 2);
    tick(10);
    check_a("abort_stays_idle", 0, 1'b0, 1'b0, 1'b0, 2);

    // Reset while code 9 is showing.
    e0 = cyc; start_a = 1'b1;
    for (int k = 0; k <= 9; k++) push_a(e0 + 1 + k * DwellA, 1'b1, 1'b0, k, 2);
    tick(1); start_a = 1'b0;
    tick(9 * DwellA + 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check_a("reset_midscan", 0, 1'b0, 1'b0, 1'b0, 0);
    tick(10);

    // Single-code scans on the LAST_CODE=0, DWELL=1 instance until pass_cnt saturates.
    pb = 0;
    for (int r = 0; r < 17; r++) begin
      e0 = cyc; start_b = 1'b1;
      push_b(e0 + 1, 1'b1, 1'b0, pb);
      pb = (pb + 1 > 15) ? 15 : pb + 1;
      push_b(e0 + 2, 1'b0, 1'b1, pb);
      tick(1); start_b = 1'b0; tick(2);
    end
    check_b("b_saturated", 1'b0, 15);
`endif

    tick(3);
    do_check("a_queue_drained", 64'(qa.size()), 64'(0));
    do_check("b_queue_drained", 64'(qb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
